// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, state encoding and bit-numbering helpers.
// Tables hold DES bit numbers (1 = MSB of the field they index).
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int PC1_TABLE [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_SCHEDULE [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // DES bit n of a [width:1] vector lives at index width+1-n.
  function automatic int des_pos(input int width, input int n);
    return width + 1 - n;
  endfunction

  // DES bit 1 is the MSB, so a DES left rotation is a vector rotation toward the MSB.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    return (x >> n) | (x << (28 - n));
  endfunction

endpackage

// File: rtl/des_key_schedule_dec_if.sv
// Key-load request and subkey-presentation handshake bundle.
interface des_key_schedule_dec_if;
  logic [64:1] Key_Input;
  logic        Dec_Mode;
  logic        Key_Load;
  logic        Subkey_Ack;
  logic [48:1] Subkey_Output;
  logic        Subkey_Valid;
  logic [5:1]  Round_Index;
  logic        Busy;
  logic        Done_Flag;

  modport master (
    output Key_Input, Dec_Mode, Key_Load, Subkey_Ack,
    input  Subkey_Output, Subkey_Valid, Round_Index, Busy, Done_Flag
  );

  modport slave (
    input  Key_Input, Dec_Mode, Key_Load, Subkey_Ack,
    output Subkey_Output, Subkey_Valid, Round_Index, Busy, Done_Flag
  );
endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2: 56-bit {C,D} to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [56:1] cd_i,
  output logic [48:1] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int j = 1; j <= 48; j++) begin
      subkey_o[des_pos(48, j)] = cd_i[des_pos(56, PC2_TABLE[j])];
    end
  end

endmodule

// File: rtl/des_key_schedule_dec.sv
// Sequential DES subkey generator: presents K16..K1 (decrypt) or K1..K16
// (encrypt) one per valid/ack handshake.
module des_key_schedule_dec
  import des_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  des_key_schedule_dec_if.slave        bus
);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic [56:1] cd_q, cd_d;
  logic [56:1] pc1_key;
  logic [4:0]  round_inc;
  logic        last_round;

  always_comb begin
    pc1_key = '0;
    for (int j = 1; j <= 56; j++) begin
      pc1_key[des_pos(56, j)] = bus.Key_Input[des_pos(64, PC1_TABLE[j])];
    end
  end

  assign round_inc  = round_q + 5'd1;
  assign last_round = mode_q ? (round_q == 5'd1) : (round_q == 5'd16);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    mode_d  = mode_q;
    cd_d    = cd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Key_Load) begin
          mode_d  = bus.Dec_Mode;
          state_d = ST_PRESENT;
          if (bus.Dec_Mode) begin
            // C16/D16 equals C0/D0 since the schedule totals 28 shifts.
            cd_d    = pc1_key;
            round_d = 5'd16;
          end else begin
            cd_d    = {rotl28(pc1_key[56:29], 1), rotl28(pc1_key[28:1], 1)};
            round_d = 5'd1;
          end
        end
      end
      ST_PRESENT: begin
        if (bus.Subkey_Ack) begin
          if (last_round) begin
            state_d = ST_DONE;
          end else if (mode_q) begin
            cd_d    = {rotr28(cd_q[56:29], SHIFT_SCHEDULE[round_q]),
                       rotr28(cd_q[28:1],  SHIFT_SCHEDULE[round_q])};
            round_d = round_q - 5'd1;
          end else begin
            cd_d    = {rotl28(cd_q[56:29], SHIFT_SCHEDULE[round_inc]),
                       rotl28(cd_q[28:1],  SHIFT_SCHEDULE[round_inc])};
            round_d = round_inc;
          end
        end
      end
      ST_DONE: begin
        round_d = 5'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 5'd0;
      mode_q  <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      cd_q    <= cd_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (bus.Subkey_Output)
  );

  assign bus.Subkey_Valid = (state_q == ST_PRESENT);
  assign bus.Round_Index  = round_q;
  assign bus.Busy         = (state_q != ST_IDLE);
  assign bus.Done_Flag    = (state_q == ST_DONE);

endmodule

// File: tb/tb_des_key_schedule_dec.sv
// Self-checking bench for des_key_schedule_dec against a forward DES key-schedule model.
module tb_des_key_schedule_dec;

  logic clk = 1'b0;
  logic rst = 1'b0;

  des_key_schedule_dec_if ifc ();

  des_key_schedule_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;

  logic [47:0] ref_k [1:16];
  logic [47:0] obs   [0:15];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Textbook forward schedule: cumulative left shifts of C/D bit arrays, K1..K16.
  task automatic model_keys(input logic [63:0] key);
    bit c [0:27];
    bit d [0:27];
    bit tc, td;
    int p;
    for (int i = 0; i < 28; i++) begin
      c[i] = key[64 - PC1[i]];
      d[i] = key[64 - PC1[i + 28]];
    end
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < ((r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2); s++) begin
        tc = c[0];
        td = d[0];
        for (int i = 0; i < 27; i++) begin
          c[i] = c[i + 1];
          d[i] = d[i + 1];
        end
        c[27] = tc;
        d[27] = td;
      end
      for (int j = 0; j < 48; j++) begin
        p = PC2[j];
        ref_k[r][47 - j] = (p <= 28) ? c[p - 1] : d[p - 29];
      end
    end
  endtask

  // Starts at a negedge in IDLE; ends at a negedge in IDLE (or at stop_round, still presenting).
  task automatic run_seq(input logic [63:0] key, input bit dec, input int gap_pct,
                         input int hold_first, input bit poke, input int stop_round);
    int  idx = 0;
    int  cycles = 0;
    int  held = 0;
    int  r;
    bit  ack;
    model_keys(key);
    ifc.Key_Input  = key;
    ifc.Dec_Mode   = dec;
    ifc.Key_Load   = 1'b1;
    ifc.Subkey_Ack = 1'b0;
    @(negedge clk);
    ifc.Key_Load  = 1'b0;
    ifc.Dec_Mode  = ~dec;
    ifc.Key_Input = {$urandom, $urandom};
    while (idx < 16 && cycles < 300) begin
      r = dec ? 16 - idx : idx + 1;
      chk("valid", ifc.Subkey_Valid, 1);
      if (!ifc.Subkey_Valid) break;
      chk("busy", ifc.Busy, 1);
      chk("round", ifc.Round_Index, r);
      chk("subkey", ifc.Subkey_Output, ref_k[r]);
      if (r == stop_round) return;
      if (idx == 0 && held < hold_first) begin
        ack = 1'b0;
        held++;
      end else begin
        ack = ($urandom_range(99) >= gap_pct);
      end
      if (ack) begin
        obs[idx] = ifc.Subkey_Output;
        idx++;
      end
      ifc.Subkey_Ack = ack;
      ifc.Key_Load   = poke && (r == 8);
      if (poke) ifc.Key_Input = 64'h0;
      @(negedge clk);
      cycles++;
    end
    chk("seq_len", idx, 16);
    ifc.Subkey_Ack = 1'($urandom_range(1));
    ifc.Key_Load   = poke;
    ifc.Key_Input  = 64'h0;
    chk("done", ifc.Done_Flag, 1);
    chk("busy_done", ifc.Busy, 1);
    chk("valid_done", ifc.Subkey_Valid, 0);
    if (gap_pct == 0 && hold_first == 0) chk("done_latency", cycles, 16);
    @(negedge clk);
    ifc.Key_Load   = 1'b0;
    ifc.Subkey_Ack = 1'b0;
    chk("done_pulse", ifc.Done_Flag, 0);
    chk("busy_idle", ifc.Busy, 0);
    chk("valid_idle", ifc.Subkey_Valid, 0);
    chk("round_idle", ifc.Round_Index, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, ifc.Subkey_Valid, 0);
    chk({tag, "_round"}, ifc.Round_Index, 0);
    chk({tag, "_busy"}, ifc.Busy, 0);
    chk({tag, "_done"}, ifc.Done_Flag, 0);
    chk({tag, "_subkey"}, ifc.Subkey_Output, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] k;
    bit          dm;
    ifc.Key_Input  = 64'h0;
    ifc.Dec_Mode   = 1'b0;
    ifc.Key_Load   = 1'b0;
    ifc.Subkey_Ack = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_vals("reset");
    ifc.Key_Load   = 1'b1;
    ifc.Subkey_Ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ifc.Key_Load = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ack_ignored", ifc.Subkey_Valid, 0);
    ifc.Subkey_Ack = 1'b0;

    // Decrypt order, ack held high; the encrypt run follows back-to-back.
    run_seq(KEY_A, 1'b1, 0, 0, 1'b0, 0);
    chk("dec_first", obs[0], 48'hCB3D8B0E17F5);
    chk("dec_second", obs[1], 48'hBF918D3D3F0A);
    chk("dec_last", obs[15], 48'h1B02EFFC7072);
    run_seq(KEY_A, 1'b0, 0, 0, 1'b0, 0);
    chk("enc_first", obs[0], 48'h1B02EFFC7072);
    chk("enc_last", obs[15], 48'hCB3D8B0E17F5);

    // Backpressure: 5-cycle hold on round 16, then random gaps.
    run_seq(KEY_A, 1'b1, 40, 5, 1'b0, 0);
    chk("bp_first", obs[0], 48'hCB3D8B0E17F5);
    chk("bp_last", obs[15], 48'h1B02EFFC7072);

    // Ignored loads during round 8 and during DONE.
    run_seq(KEY_A, 1'b1, 20, 0, 1'b1, 0);
    run_seq(KEY_A, 1'b0, 20, 0, 1'b1, 0);

    // Asynchronous reset while round 10 is presented.
    run_seq(KEY_A, 1'b1, 0, 0, 1'b0, 10);
    rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    ifc.Subkey_Ack = 1'b0;
    @(negedge clk);
    run_seq(KEY_A, 1'b1, 0, 0, 1'b0, 0);
    chk("rst_restart", obs[0], 48'hCB3D8B0E17F5);

    // Parity bits flipped: same subkeys.
    run_seq(KEY_P, 1'b1, 0, 0, 1'b0, 0);
    chk("par_first", obs[0], 48'hCB3D8B0E17F5);
    chk("par_last", obs[15], 48'h1B02EFFC7072);

    for (int n = 0; n < 8; n++) begin
      k  = {$urandom, $urandom};
      dm = 1'($urandom_range(1));
      run_seq(k, dm, $urandom_range(50), $urandom_range(3), 1'($urandom_range(1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
